// File: rtl/wb_slave_interface_pkg.sv
// Shared bus widths, cycle-type codes, FSM states and buffer beat layout
// for the WISHBONE slave port of the NIC.
package wb_slave_interface_pkg;

  localparam int BUS_ADDRESS_WIDTH = 32;
  localparam int BUS_DATA_WIDTH    = 32;
  localparam int GRANULARITY       = 8;
  localparam int SEL_WIDTH         = BUS_DATA_WIDTH / GRANULARITY;
  localparam int MAX_BURST_LENGHT  = 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RBURST = 2'd2,
    HOLD   = 2'd3
  } wb_state_t;

  // One buffered write beat: byte selects alongside the data word.
  typedef struct packed {
    logic [SEL_WIDTH-1:0]      sel;
    logic [BUS_DATA_WIDTH-1:0] data;
  } beat_t;

  // Only classic, incrementing and end-of-burst cycles are understood.
  function automatic logic cti_legal(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_INCR) || (cti == CTI_END);
  endfunction

endpackage

// File: rtl/wb_slave_interface_if.sv
// Pipelined WISHBONE B4 bus bundle between the far-bus master and this slave.
interface wb_slave_interface_if;
  import wb_slave_interface_pkg::*;

  logic                         cyc;
  logic                         stb;
  logic                         we;
  logic [BUS_ADDRESS_WIDTH-1:0] adr;
  logic [BUS_DATA_WIDTH-1:0]    dat_w;
  logic [SEL_WIDTH-1:0]         sel;
  logic [2:0]                   cti;
  logic [BUS_DATA_WIDTH-1:0]    dat_r;
  logic                         ack;
  logic                         rty;
  logic                         err;
  logic                         stall;

  modport master (
    output cyc, stb, we, adr, dat_w, sel, cti,
    input  dat_r, ack, rty, err, stall
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel, cti,
    output dat_r, ack, rty, err, stall
  );

endinterface

// File: rtl/wb_slave_interface_nic_sync_fifo.sv
// Small synchronous FIFO holding the write beats of one message.
// DEPTH must be a power of two (>= 2); pointers carry one wrap bit.
module nic_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Head reads as zero when empty so the queue never sees stale beats.
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; flush drops everything in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (push && !full && !rst && !flush)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_slave_interface.sv
// WISHBONE B4 pipelined slave port of the NIC. Write cycles (single or
// incrementing burst) are collected into a message buffer for the output
// queue; reads are answered from a held reply or turned into a read-request
// message with a retry to the master.
module wb_slave_interface
  import wb_slave_interface_pkg::*;
#(
  parameter int N_BITS_BURST_LENGHT = $clog2(MAX_BURST_LENGHT),
  parameter int BUFFER_DEPTH        = MAX_BURST_LENGHT
) (
  input  logic                           clk,
  input  logic                           rst,
  wb_slave_interface_if.slave            wb,
  output logic                           message_valid_o,
  output logic [BUS_ADDRESS_WIDTH-1:0]   address_o,
  output logic                           transaction_type_o,
  output logic [N_BITS_BURST_LENGHT-1:0] burst_lenght_o,
  output logic [BUS_DATA_WIDTH-1:0]      data_o,
  output logic [SEL_WIDTH-1:0]           sel_o,
  input  logic                           next_data_i,
  input  logic                           message_consumed_i,
  input  logic                           reply_valid_i,
  input  logic [BUS_ADDRESS_WIDTH-1:0]   reply_address_i,
  input  logic [BUS_DATA_WIDTH-1:0]      reply_data_i,
  output logic                           reply_next_o
);

  // Counter must reach BUFFER_DEPTH itself to detect a burst that overruns.
  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = BUFFER_DEPTH;

  wb_state_t                 state;
  logic [CNT_W-1:0]          beat_cnt;
  logic                      ack, rty, err;
  logic [BUS_DATA_WIDTH-1:0] dat_r;

  logic  stall, accepted, cti_ok, cti_end, reply_hit;
  logic  wr_burst_beat, wburst_bad, idle_push;
  logic  push, pop, flush, buf_full, buf_empty;
  beat_t head;

  // Only a read burst waiting on reply data holds the bus.
  assign stall     = (state == RBURST) && !reply_valid_i;
  assign accepted  = wb.cyc && wb.stb && !stall;
  assign cti_ok    = cti_legal(wb.cti);
  assign cti_end   = (wb.cti == CTI_END);
  assign reply_hit = reply_valid_i && (wb.adr == reply_address_i);

  // Buffer control, decided from registered state and this cycle's beat.
  assign wr_burst_beat = (state == WBURST) && accepted;
  assign wburst_bad    = wr_burst_beat && (!wb.we || (beat_cnt == CNT_FULL) || !cti_ok);
  assign idle_push     = (state == IDLE) && accepted && !message_valid_o && cti_ok && wb.we;
  assign push          = (idle_push || (wr_burst_beat && !wburst_bad)) && !buf_full;
  assign flush         = wburst_bad || ((state == HOLD) && message_consumed_i);
  assign pop           = (state == HOLD) && next_data_i && !buf_empty;

  nic_sync_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (BUFFER_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({wb.sel, wb.dat_w}),
    .dout  (head),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign data_o    = head.data;
  assign sel_o     = head.sel;
  assign wb.ack    = ack;
  assign wb.rty    = rty;
  assign wb.err    = err;
  assign wb.stall  = stall;
  assign wb.dat_r  = dat_r;

  // Main FSM: one registered termination per accepted beat, message latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      beat_cnt           <= '0;
      ack                <= 1'b0;
      rty                <= 1'b0;
      err                <= 1'b0;
      dat_r              <= '0;
      reply_next_o       <= 1'b0;
      message_valid_o    <= 1'b0;
      address_o          <= '0;
      transaction_type_o <= 1'b0;
      burst_lenght_o     <= '0;
    end else begin
      ack          <= 1'b0;
      rty          <= 1'b0;
      err          <= 1'b0;
      dat_r        <= '0;
      reply_next_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accepted) begin
            if (message_valid_o) begin
              rty <= 1'b1;
            end else if (!cti_ok) begin
              err <= 1'b1;
            end else if (wb.we) begin
              ack                <= 1'b1;
              address_o          <= wb.adr;
              transaction_type_o <= 1'b1;
              beat_cnt           <= CNT_ONE;
              if (wb.cti == CTI_INCR) begin
                state <= WBURST;
              end else begin
                burst_lenght_o  <= '0;
                message_valid_o <= 1'b1;
                state           <= HOLD;
              end
            end else if (reply_hit) begin
              ack          <= 1'b1;
              dat_r        <= reply_data_i;
              reply_next_o <= 1'b1;
              if (wb.cti == CTI_INCR)
                state <= RBURST;
            end else begin
              // No reply held: forward a read request and ask for a retry.
              rty                <= 1'b1;
              address_o          <= wb.adr;
              transaction_type_o <= 1'b0;
              burst_lenght_o     <= '0;
              message_valid_o    <= 1'b1;
              state              <= HOLD;
            end
          end
        end
        WBURST: begin
          if (!wb.cyc) begin
            // Master abandoned the burst early: keep what arrived.
            burst_lenght_o  <= N_BITS_BURST_LENGHT'(beat_cnt - CNT_ONE);
            message_valid_o <= 1'b1;
            state           <= HOLD;
          end else if (accepted) begin
            if (wburst_bad) begin
              err      <= 1'b1;
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              ack <= 1'b1;
              if (beat_cnt != CNT_FULL)
                beat_cnt <= beat_cnt + CNT_ONE;
              if (cti_end) begin
                // This beat is the last one, so the length is the old count.
                burst_lenght_o  <= N_BITS_BURST_LENGHT'(beat_cnt);
                message_valid_o <= 1'b1;
                state           <= HOLD;
              end
            end
          end
        end
        RBURST: begin
          if (!wb.cyc) begin
            state <= IDLE;
          end else if (accepted) begin
            ack          <= 1'b1;
            dat_r        <= reply_data_i;
            reply_next_o <= 1'b1;
            if (cti_end)
              state <= IDLE;
          end
        end
        HOLD: begin
          if (accepted)
            rty <= 1'b1;
          if (message_consumed_i) begin
            message_valid_o <= 1'b0;
            beat_cnt        <= '0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_interface.sv
// Directed bench for wb_slave_interface: a queue-based message model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_wb_slave_interface;
  import wb_slave_interface_pkg::*;

  localparam int DEPTH = MAX_BURST_LENGHT;
  localparam int LW    = $clog2(MAX_BURST_LENGHT);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_slave_interface_if bus();

  logic          message_valid_o, transaction_type_o, reply_next_o;
  logic [31:0]   address_o, data_o, reply_address_i, reply_data_i;
  logic [LW-1:0] burst_lenght_o;
  logic [3:0]    sel_o;
  logic          next_data_i, message_consumed_i, reply_valid_i;

  wb_slave_interface dut (
    .clk                (clk),
    .rst                (rst),
    .wb                 (bus),
    .message_valid_o    (message_valid_o),
    .address_o          (address_o),
    .transaction_type_o (transaction_type_o),
    .burst_lenght_o     (burst_lenght_o),
    .data_o             (data_o),
    .sel_o              (sel_o),
    .next_data_i        (next_data_i),
    .message_consumed_i (message_consumed_i),
    .reply_valid_i      (reply_valid_i),
    .reply_address_i    (reply_address_i),
    .reply_data_i       (reply_data_i),
    .reply_next_o       (reply_next_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [35:0] mq[$];          // buffered {sel,data} beats
  bit          m_pend, m_coll, m_read, m_type, started;
  logic [31:0] m_addr;
  int          m_len;
  bit          e_ack, e_rty, e_err, e_rn, e_dv;
  logic [31:0] e_dat;

  always @(posedge clk) begin
    bit acc, legal;
    logic [2:0] c;
    e_ack = 0; e_rty = 0; e_err = 0; e_rn = 0; e_dv = 0; e_dat = '0;
    if (rst) begin
      mq.delete();
      m_pend = 0; m_coll = 0; m_read = 0; m_type = 0; m_addr = '0; m_len = 0;
      started = 1;
    end else begin
      acc   = bus.cyc && bus.stb && !(m_read && !reply_valid_i);
      c     = bus.cti;
      legal = (c == 3'b000) || (c == 3'b010) || (c == 3'b111);
      if (m_pend) begin
        if (acc) e_rty = 1;
        if (message_consumed_i) begin
          m_pend = 0;
          mq.delete();
        end else if (next_data_i && mq.size() > 0) begin
          void'(mq.pop_front());
        end
      end else if (m_coll) begin
        if (!bus.cyc) begin
          m_coll = 0; m_pend = 1; m_len = mq.size() - 1;
        end else if (acc) begin
          if (!bus.we || mq.size() == DEPTH || !legal) begin
            e_err = 1; m_coll = 0; mq.delete();
          end else begin
            e_ack = 1;
            mq.push_back({bus.sel, bus.dat_w});
            if (c == 3'b111) begin
              m_coll = 0; m_pend = 1; m_len = mq.size() - 1;
            end
          end
        end
      end else if (m_read) begin
        if (!bus.cyc) m_read = 0;
        else if (acc) begin
          e_ack = 1; e_dv = 1; e_dat = reply_data_i; e_rn = 1;
          if (c == 3'b111) m_read = 0;
        end
      end else if (acc) begin
        if (!legal) begin
          e_err = 1;
        end else if (bus.we) begin
          e_ack = 1;
          mq.push_back({bus.sel, bus.dat_w});
          m_addr = bus.adr; m_type = 1;
          if (c == 3'b010) m_coll = 1;
          else begin m_pend = 1; m_len = 0; end
        end else if (reply_valid_i && bus.adr == reply_address_i) begin
          e_ack = 1; e_dv = 1; e_dat = reply_data_i; e_rn = 1;
          if (c == 3'b010) m_read = 1;
        end else begin
          e_rty = 1; m_pend = 1; m_addr = bus.adr; m_type = 0; m_len = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("ack", 64'(bus.ack), 64'(e_ack));
      chk("rty", 64'(bus.rty), 64'(e_rty));
      chk("err", 64'(bus.err), 64'(e_err));
      chk("reply_next", 64'(reply_next_o), 64'(e_rn));
      chk("stall", 64'(bus.stall), 64'(m_read && !reply_valid_i));
      chk("msg_valid", 64'(message_valid_o), 64'(m_pend));
      chk("data_o", 64'(data_o), 64'(mq.size() > 0 ? mq[0][31:0] : 32'h0));
      chk("sel_o", 64'(sel_o), 64'(mq.size() > 0 ? mq[0][35:32] : 4'h0));
      if (e_dv) chk("dat_r", 64'(bus.dat_r), 64'(e_dat));
      if (m_pend) begin
        chk("address_o", 64'(address_o), 64'(m_addr));
        chk("type_o", 64'(transaction_type_o), 64'(m_type));
        chk("len_o", 64'(burst_lenght_o), 64'(m_len));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic bt(input bit we, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [2:0] c);
    bus.cyc = 1; bus.stb = 1; bus.we = we; bus.adr = a;
    bus.dat_w = d; bus.sel = s; bus.cti = c;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.cti = 3'b000;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic consume();
    bus.cyc = 0; bus.stb = 0;
    message_consumed_i = 1;
    @(posedge clk); #1;
    message_consumed_i = 0;
  endtask

  initial begin
    rst = 1;
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.adr = '0;
    bus.dat_w = '0; bus.sel = '0; bus.cti = '0;
    next_data_i = 0; message_consumed_i = 0; reply_valid_i = 0;
    reply_address_i = '0; reply_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_ack", 64'(bus.ack), 64'd0);
    chk("rst_rty", 64'(bus.rty), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_mv", 64'(message_valid_o), 64'd0);
    chk("rst_addr", 64'(address_o), 64'd0);
    chk("rst_len", 64'(burst_lenght_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    rst = 0;
    idle(1);

    // single classic write
    bt(1, 32'h100, 32'hDEADBEEF, 4'hF, 3'b000);
    chk("w1_ack", 64'(bus.ack), 64'd1);
    chk("w1_mv", 64'(message_valid_o), 64'd1);
    chk("w1_type", 64'(transaction_type_o), 64'd1);
    chk("w1_len", 64'(burst_lenght_o), 64'd0);
    chk("w1_data", 64'(data_o), 64'hDEADBEEF);
    chk("w1_addr", 64'(address_o), 64'h100);
    idle(1);
    consume();
    chk("w1_freed", 64'(message_valid_o), 64'd0);

    // 5-beat incrementing burst, back to back
    for (int i = 0; i < 5; i++) begin
      bt(1, 32'h300, 32'hA0 + 32'(i), 4'(i + 1), (i == 4) ? 3'b111 : 3'b010);
      chk("b5_ack", 64'(bus.ack), 64'd1);
    end
    chk("b5_len", 64'(burst_lenght_o), 64'd4);
    chk("b5_mv", 64'(message_valid_o), 64'd1);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      chk("b5_pop", 64'(data_o), 64'hA0 + 64'(i));
      next_data_i = 1;
      @(posedge clk); #1;
      next_data_i = 0;
    end
    chk("b5_drained", 64'(data_o), 64'd0);
    consume();

    // write while a message is held, and consume racing a new strobe
    bt(1, 32'h400, 32'h11, 4'hF, 3'b000);
    bt(1, 32'h404, 32'h22, 4'hF, 3'b000);
    chk("hold_rty", 64'(bus.rty), 64'd1);
    chk("hold_noack", 64'(bus.ack), 64'd0);
    message_consumed_i = 1;
    bt(1, 32'h408, 32'h33, 4'hF, 3'b000);
    message_consumed_i = 0;
    chk("race_rty", 64'(bus.rty), 64'd1);
    bt(1, 32'h40C, 32'h44, 4'hF, 3'b000);
    chk("after_ack", 64'(bus.ack), 64'd1);
    chk("after_addr", 64'(address_o), 64'h40C);
    idle(1);
    consume();

    // split read: request then served from held reply
    bt(0, 32'h200, 32'h0, 4'hF, 3'b000);
    chk("rd_rty", 64'(bus.rty), 64'd1);
    chk("rd_type", 64'(transaction_type_o), 64'd0);
    chk("rd_addr", 64'(address_o), 64'h200);
    idle(1);
    consume();
    reply_valid_i = 1; reply_address_i = 32'h200; reply_data_i = 32'h12345678;
    bt(0, 32'h200, 32'h0, 4'hF, 3'b000);
    chk("rd_ack", 64'(bus.ack), 64'd1);
    chk("rd_dat", 64'(bus.dat_r), 64'h12345678);
    chk("rd_next", 64'(reply_next_o), 64'd1);
    // read burst with a stall while the reply is not ready
    reply_data_i = 32'hA1;
    bt(0, 32'h200, 32'h0, 4'hF, 3'b010);
    reply_valid_i = 0;
    bt(0, 32'h200, 32'h0, 4'hF, 3'b010);
    chk("rb_stall", 64'(bus.stall), 64'd1);
    chk("rb_noack", 64'(bus.ack), 64'd0);
    reply_valid_i = 1; reply_data_i = 32'hA2;
    bt(0, 32'h200, 32'h0, 4'hF, 3'b010);
    chk("rb_dat", 64'(bus.dat_r), 64'hA2);
    reply_data_i = 32'hA3;
    bt(0, 32'h200, 32'h0, 4'hF, 3'b111);
    idle(1);
    reply_valid_i = 0;

    // CYC dropped mid write burst keeps beats so far
    for (int i = 0; i < 3; i++) bt(1, 32'h500, 32'hB0 + 32'(i), 4'hF, 3'b010);
    idle(1);
    chk("cyc_mv", 64'(message_valid_o), 64'd1);
    chk("cyc_len", 64'(burst_lenght_o), 64'd2);
    consume();

    // WE changing mid burst
    bt(1, 32'h600, 32'h1, 4'hF, 3'b010);
    bt(0, 32'h600, 32'h2, 4'hF, 3'b010);
    chk("we_err", 64'(bus.err), 64'd1);
    idle(1);

    // overrun: BUFFER_DEPTH+1 beats without end-of-burst
    for (int i = 0; i <= DEPTH; i++) bt(1, 32'h700, 32'(i), 4'hF, 3'b010);
    chk("ovf_err", 64'(bus.err), 64'd1);
    chk("ovf_mv", 64'(message_valid_o), 64'd0);
    chk("ovf_data", 64'(data_o), 64'd0);
    idle(1);
    chk("ovf_mv2", 64'(message_valid_o), 64'd0);

    // unsupported cycle type
    bt(1, 32'h800, 32'h5, 4'hF, 3'b001);
    chk("cti_err", 64'(bus.err), 64'd1);
    chk("cti_mv", 64'(message_valid_o), 64'd0);
    idle(1);

    // reset on the third beat of a burst
    bt(1, 32'h900, 32'h1, 4'hF, 3'b010);
    bt(1, 32'h900, 32'h2, 4'hF, 3'b010);
    rst = 1;
    bt(1, 32'h900, 32'h3, 4'hF, 3'b010);
    rst = 0;
    chk("mid_rst_ack", 64'(bus.ack), 64'd0);
    chk("mid_rst_err", 64'(bus.err), 64'd0);
    chk("mid_rst_mv", 64'(message_valid_o), 64'd0);
    chk("mid_rst_data", 64'(data_o), 64'd0);
    idle(1);
    bt(1, 32'hA00, 32'hCAFEF00D, 4'hF, 3'b000);
    chk("post_rst_ack", 64'(bus.ack), 64'd1);
    chk("post_rst_data", 64'(data_o), 64'hCAFEF00D);
    idle(1);
    consume();
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
